// File: rtl/enemy_bomb.sv
// enemy_bomb: alien projectile. A pseudo-random cooldown picks when to fire,
// a probe walks the fleet columns from a random start to find a live alien,
// the bomb then falls one step per frame until it lands on the paddle (one
// cycle paddle_hit pulse) or leaves the bottom of the screen.
//
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   enable               game running; low parks the block in IDLE
//   frame_tick           one-cycle pulse per video frame
//   fleet_x, fleet_y     fleet origin, sampled only at spawn
//   alive_cols           bit c set: fleet column c has a live alien
//   paddle_x             paddle left edge
//   hcount, vcount       pixel scan position
//   bomb_active          bomb in flight
//   bomb_x, bomb_y       bomb top-left corner
//   paddle_hit           one-cycle pulse when the bomb lands on the paddle
//   pixel_on, pixel_rgb  registered bomb pixel and colour (0 when off)

`timescale 1ns/1ps

module enemy_bomb #(
    parameter int          HRES        = 1280,
    parameter int          VRES        = 720,
    parameter int          BOMB_W      = 4,
    parameter int          BOMB_H      = 16,
    parameter int          BOMB_SPEED  = 8,
    parameter logic [23:0] BOMB_COLOR  = 24'hFF3030,
    parameter int          PADDLE_W    = 50,
    parameter int          PADDLE_H    = 20,
    parameter int          ENEMY_W     = 32,
    parameter int          ENEMY_H     = 28,
    parameter int          COL_PITCH   = 48,
    parameter int          FIRE_PERIOD = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        frame_tick,
    input  logic [10:0] fleet_x,
    input  logic [9:0]  fleet_y,
    input  logic [7:0]  alive_cols,
    input  logic [10:0] paddle_x,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic        bomb_active,
    output logic [10:0] bomb_x,
    output logic [9:0]  bomb_y,
    output logic        paddle_hit,
    output logic        pixel_on,
    output logic [23:0] pixel_rgb
);

    // Wide enough for FIRE_PERIOD plus the largest random extra (15).
    localparam int CD_W = $clog2(FIRE_PERIOD + 16);

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StFall,
        StHit
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [CD_W-1:0] cooldown_q, cooldown_d;
    logic [CD_W-1:0] cooldown_reload;
    logic [2:0]  col_q, col_d;
    logic [2:0]  probe_q, probe_d;
    logic [10:0] bomb_x_q, bomb_x_d;
    logic [9:0]  bomb_y_q, bomb_y_d;
    logic        pixel_on_q;
    logic [23:0] pixel_rgb_q;

    // 12-bit position intermediates: no sum below can wrap.
    logic [11:0] spawn_x12;
    logic [11:0] spawn_y12;
    logic [11:0] fall_y12;
    logic [11:0] bomb_x12;
    logic [11:0] bomb_y12;
    logic [11:0] paddle_x12;
    logic [11:0] hcount12;
    logic [11:0] vcount12;
    logic        spawn_ok;
    logic        over_paddle;
    logic        reach_paddle;
    logic        reach_floor;
    logic        pixel_hit;

    // Fibonacci LFSR, taps 16,14,13,11. Maximal length, so a non-zero seed
    // never reaches the all-zero lock-up state.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_comb begin
        cooldown_reload = CD_W'(FIRE_PERIOD) + CD_W'(lfsr_q[3:0]);

        bomb_x12   = 12'(bomb_x_q);
        bomb_y12   = 12'(bomb_y_q);
        paddle_x12 = 12'(paddle_x);
        hcount12   = 12'(hcount);
        vcount12   = 12'(vcount);

        spawn_x12 = 12'(fleet_x) + 12'(col_q) * 12'(COL_PITCH)
                  + 12'((ENEMY_W - BOMB_W) / 2);
        spawn_y12 = 12'(fleet_y) + 12'(ENEMY_H);
        fall_y12  = bomb_y12 + 12'(BOMB_SPEED);

        // A bomb that would start partly off-screen is not fired at all.
        spawn_ok = (spawn_x12 + 12'(BOMB_W) <= 12'(HRES))
                && (spawn_y12 + 12'(BOMB_H) < 12'(VRES));

        over_paddle  = (bomb_x12 < paddle_x12 + 12'(PADDLE_W))
                    && (bomb_x12 + 12'(BOMB_W) > paddle_x12);
        reach_paddle = (fall_y12 + 12'(BOMB_H) >= 12'(VRES - PADDLE_H));
        reach_floor  = (fall_y12 + 12'(BOMB_H) >= 12'(VRES));

        pixel_hit = (state_q == StFall)
                 && (hcount12 >= bomb_x12) && (hcount12 < bomb_x12 + 12'(BOMB_W))
                 && (vcount12 >= bomb_y12) && (vcount12 < bomb_y12 + 12'(BOMB_H));
    end

    always_comb begin
        state_d    = state_q;
        cooldown_d = cooldown_q;
        col_d      = col_q;
        probe_d    = probe_q;
        bomb_x_d   = bomb_x_q;
        bomb_y_d   = bomb_y_q;

        if (!enable) begin
            // Disable wins over any tick or pending hit in the same cycle.
            state_d    = StIdle;
            cooldown_d = cooldown_reload;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cooldown_q == '0) begin
                        state_d = StArm;
                        col_d   = lfsr_q[2:0];
                        probe_d = '0;
                    end else if (frame_tick) begin
                        cooldown_d = cooldown_q - 1'b1;
                    end
                end

                StArm: begin
                    if (alive_cols == '0) begin
                        state_d    = StIdle;
                        cooldown_d = cooldown_reload;
                    end else if (alive_cols[col_q]) begin
                        if (spawn_ok) begin
                            state_d  = StFall;
                            bomb_x_d = spawn_x12[10:0];
                            bomb_y_d = spawn_y12[9:0];
                        end else begin
                            state_d    = StIdle;
                            cooldown_d = cooldown_reload;
                        end
                    end else if (probe_q == 3'd7) begin
                        state_d    = StIdle;
                        cooldown_d = cooldown_reload;
                    end else begin
                        col_d   = col_q + 3'd1;
                        probe_d = probe_q + 3'd1;
                    end
                end

                StFall: begin
                    // Moves only from FALL, so the spawn cycle never moves.
                    if (frame_tick) begin
                        if (reach_paddle && over_paddle) begin
                            state_d  = StHit;
                            bomb_y_d = fall_y12[9:0];
                        end else if (reach_floor) begin
                            // Off-screen position is never written out.
                            state_d    = StIdle;
                            cooldown_d = cooldown_reload;
                        end else begin
                            bomb_y_d = fall_y12[9:0];
                        end
                    end
                end

                StHit: begin
                    state_d    = StIdle;
                    cooldown_d = cooldown_reload;
                end

                default: begin
                    state_d    = StIdle;
                    cooldown_d = cooldown_reload;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            lfsr_q      <= 16'hACE1;
            cooldown_q  <= CD_W'(FIRE_PERIOD);
            col_q       <= '0;
            probe_q     <= '0;
            bomb_x_q    <= '0;
            bomb_y_q    <= '0;
            pixel_on_q  <= 1'b0;
            pixel_rgb_q <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cooldown_q  <= cooldown_d;
            col_q       <= col_d;
            probe_q     <= probe_d;
            bomb_x_q    <= bomb_x_d;
            bomb_y_q    <= bomb_y_d;
            pixel_on_q  <= pixel_hit;
            pixel_rgb_q <= pixel_hit ? BOMB_COLOR : 24'h0;
        end
    end

    assign bomb_active = (state_q == StFall);
    assign paddle_hit  = (state_q == StHit);
    assign bomb_x      = bomb_x_q;
    assign bomb_y      = bomb_y_q;
    assign pixel_on    = pixel_on_q;
    assign pixel_rgb   = pixel_rgb_q;

endmodule

// File: tb/tb_enemy_bomb.sv
// Self-checking bench for enemy_bomb: reset, spawn timing/position, fall to
// paddle hit and to floor, empty fleet, enable precedence, pixel output.

`timescale 1ns/1ps

module tb_enemy_bomb;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        frame_tick;
    logic [10:0] fleet_x;
    logic [9:0]  fleet_y;
    logic [7:0]  alive_cols;
    logic [10:0] paddle_x;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        bomb_active;
    logic [10:0] bomb_x;
    logic [9:0]  bomb_y;
    logic        paddle_hit;
    logic        pixel_on;
    logic [23:0] pixel_rgb;

    int checks = 0;
    int errors = 0;

    enemy_bomb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .frame_tick (frame_tick),
        .fleet_x    (fleet_x),
        .fleet_y    (fleet_y),
        .alive_cols (alive_cols),
        .paddle_x   (paddle_x),
        .hcount     (hcount),
        .vcount     (vcount),
        .bomb_active(bomb_active),
        .bomb_x     (bomb_x),
        .bomb_y     (bomb_y),
        .paddle_hit (paddle_hit),
        .pixel_on   (pixel_on),
        .pixel_rgb  (pixel_rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] h;
        logic [9:0]  v;
        logic        on;
        logic [23:0] rgb;
    } pix_vec_t;

    typedef struct {
        logic [7:0]  alive;
        logic [10:0] fx;
        logic [9:0]  fy;
        logic [10:0] exp_x;
        logic [9:0]  exp_y;
    } spawn_vec_t;

    pix_vec_t   pix_tab[8];
    spawn_vec_t spawn_tab[3];
    pix_vec_t   pix_q[$];
    spawn_vec_t spawn_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Called at a negedge; returns at the negedge after the consuming edge.
    task automatic frame_pulse();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    // Frame ticks 12 cycles apart until the bomb appears; n = ticks used.
    task automatic wait_spawn(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int t = 1; t <= 90 && !ok; t++) begin
            frame_pulse();
            for (int c = 0; c < 11 && !ok; c++) begin
                @(negedge clk);
                if (bomb_active) begin
                    ok = 1'b1;
                    n  = t;
                end
            end
        end
    endtask

    task automatic restart();
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
    endtask

    initial begin
        int         n;
        bit         ok;
        pix_vec_t   pexp;
        spawn_vec_t sexp;
        int         gone;

        pix_tab[0] = '{h: 11'd115, v: 10'd110, on: 1'b1, rgb: 24'hFF3030};
        pix_tab[1] = '{h: 11'd118, v: 10'd110, on: 1'b0, rgb: 24'h0};
        pix_tab[2] = '{h: 11'd114, v: 10'd108, on: 1'b1, rgb: 24'hFF3030};
        pix_tab[3] = '{h: 11'd117, v: 10'd123, on: 1'b1, rgb: 24'hFF3030};
        pix_tab[4] = '{h: 11'd113, v: 10'd110, on: 1'b0, rgb: 24'h0};
        pix_tab[5] = '{h: 11'd115, v: 10'd124, on: 1'b0, rgb: 24'h0};
        pix_tab[6] = '{h: 11'd115, v: 10'd107, on: 1'b0, rgb: 24'h0};
        pix_tab[7] = '{h: 11'd116, v: 10'd120, on: 1'b1, rgb: 24'hFF3030};

        spawn_tab[0] = '{alive: 8'h80, fx: 11'd100, fy: 10'd80,  exp_x: 11'd450, exp_y: 10'd108};
        spawn_tab[1] = '{alive: 8'h10, fx: 11'd200, fy: 10'd150, exp_x: 11'd406, exp_y: 10'd178};
        spawn_tab[2] = '{alive: 8'h04, fx: 11'd0,   fy: 10'd0,   exp_x: 11'd110, exp_y: 10'd28};

        rst_n      = 1'b0;
        enable     = 1'b1;
        frame_tick = 1'b0;
        fleet_x    = 11'd100;
        fleet_y    = 10'd80;
        alive_cols = 8'h01;
        paddle_x   = 11'd400;
        hcount     = '0;
        vcount     = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_active", 32'(bomb_active), 0);
        check("rst_x", 32'(bomb_x), 0);
        check("rst_y", 32'(bomb_y), 0);
        check("rst_hit", 32'(paddle_hit), 0);
        check("rst_pix", 32'(pixel_on), 0);
        check("rst_rgb", 32'(pixel_rgb), 0);
        rst_n = 1'b1;

        // Cooldown starts at exactly FIRE_PERIOD out of reset
        wait_spawn(n, ok);
        check("spawn1_ok", 32'(ok), 1);
        check("spawn1_ticks", 32'(n), 60);
        check("spawn1_x", 32'(bomb_x), 114);
        check("spawn1_y", 32'(bomb_y), 108);

        // Pixel vectors through a one-deep scoreboard
        for (int i = 0; i < 8; i++) begin
            hcount = pix_tab[i].h;
            vcount = pix_tab[i].v;
            pix_q.push_back(pix_tab[i]);
            @(negedge clk);
            pexp = pix_q.pop_front();
            check($sformatf("pix_on[%0d]", i), 32'(pixel_on), 32'(pexp.on));
            check($sformatf("pix_rgb[%0d]", i), 32'(pixel_rgb), 32'(pexp.rgb));
        end
        hcount = '0;
        vcount = '0;

        // Fall to the floor missing the paddle; fleet changes must not matter
        for (int k = 1; k <= 74; k++) begin
            frame_pulse();
            if (k == 10) begin
                fleet_x    = 11'd300;
                fleet_y    = 10'd200;
                alive_cols = 8'hFF;
            end
            check($sformatf("miss_y[%0d]", k), 32'(bomb_y), 32'(108 + 8 * k));
            check("miss_active", 32'(bomb_active), 1);
            check("miss_nohit", 32'(paddle_hit), 0);
            check("miss_x", 32'(bomb_x), 114);
        end
        frame_pulse();
        check("floor_active", 32'(bomb_active), 0);
        check("floor_nohit", 32'(paddle_hit), 0);
        check_range("floor_y", int'(bomb_y), 0, 719);
        fleet_x    = 11'd100;
        fleet_y    = 10'd80;
        alive_cols = 8'h01;

        // Paddle hit
        paddle_x = 11'd100;
        restart();
        wait_spawn(n, ok);
        check("spawn2_ok", 32'(ok), 1);
        check_range("spawn2_ticks", n, 60, 75);
        check("spawn2_x", 32'(bomb_x), 114);
        for (int k = 1; k <= 71; k++) begin
            frame_pulse();
            check("hit_pre_nohit", 32'(paddle_hit), 0);
            check("hit_pre_active", 32'(bomb_active), 1);
        end
        frame_pulse();
        check("hit_pulse", 32'(paddle_hit), 1);
        check("hit_y", 32'(bomb_y), 684);
        check("hit_active", 32'(bomb_active), 0);
        @(negedge clk);
        check("hit_pulse_end", 32'(paddle_hit), 0);
        check("hit_after_active", 32'(bomb_active), 0);

        // Spawn column / origin table
        foreach (spawn_tab[i]) begin
            alive_cols = spawn_tab[i].alive;
            fleet_x    = spawn_tab[i].fx;
            fleet_y    = spawn_tab[i].fy;
            spawn_q.push_back(spawn_tab[i]);
            restart();
            wait_spawn(n, ok);
            sexp = spawn_q.pop_front();
            check($sformatf("tab_ok[%0d]", i), 32'(ok), 1);
            check_range($sformatf("tab_ticks[%0d]", i), n, 60, 75);
            check($sformatf("tab_x[%0d]", i), 32'(bomb_x), 32'(sexp.exp_x));
            check($sformatf("tab_y[%0d]", i), 32'(bomb_y), 32'(sexp.exp_y));
        end

        // Empty fleet: never fires
        alive_cols = 8'h00;
        restart();
        gone = 0;
        for (int f = 0; f < 200; f++) begin
            frame_pulse();
            for (int c = 0; c < 11; c++) begin
                @(negedge clk);
                if (bomb_active) gone++;
            end
        end
        check("empty_fleet_active", 32'(gone), 0);

        // enable drop on the hitting tick beats both the move and the hit
        alive_cols = 8'h01;
        fleet_x    = 11'd100;
        fleet_y    = 10'd80;
        paddle_x   = 11'd100;
        restart();
        wait_spawn(n, ok);
        check("spawn3_ok", 32'(ok), 1);
        repeat (71) frame_pulse();
        check("en_pre_y", 32'(bomb_y), 676);
        enable     = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("en_active", 32'(bomb_active), 0);
        check("en_nohit", 32'(paddle_hit), 0);
        check("en_y_held", 32'(bomb_y), 676);
        @(negedge clk);
        check("en_nohit2", 32'(paddle_hit), 0);
        enable = 1'b1;
        wait_spawn(n, ok);
        check("en_restart_ok", 32'(ok), 1);
        check_range("en_restart_ticks", n, 60, 75);

        // frame_tick held high: spawn cycle does not move the bomb
        paddle_x = 11'd400;
        restart();
        frame_tick = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (bomb_active) ok = 1'b1;
        end
        check("cont_ok", 32'(ok), 1);
        check("cont_spawn_y", 32'(bomb_y), 108);
        @(negedge clk);
        check("cont_first_move", 32'(bomb_y), 116);
        gone = 0;
        for (int c = 0; c < 100 && bomb_active; c++) begin
            @(negedge clk);
            if (bomb_y >= 10'd720 || paddle_hit) gone++;
        end
        frame_tick = 1'b0;
        check("cont_bounds", 32'(gone), 0);
        check("cont_landed", 32'(bomb_active), 0);

        // Reset mid-flight
        restart();
        wait_spawn(n, ok);
        check("spawn4_ok", 32'(ok), 1);
        hcount = 11'd115;
        vcount = 10'd110;
        repeat (2) @(negedge clk);
        check("pre_rst_pix", 32'(pixel_on), 1);
        rst_n      = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("mid_rst_active", 32'(bomb_active), 0);
        check("mid_rst_x", 32'(bomb_x), 0);
        check("mid_rst_y", 32'(bomb_y), 0);
        check("mid_rst_hit", 32'(paddle_hit), 0);
        check("mid_rst_pix", 32'(pixel_on), 0);
        check("mid_rst_rgb", 32'(pixel_rgb), 0);
        rst_n = 1'b1;
        hcount = '0;
        vcount = '0;
        wait_spawn(n, ok);
        check("post_rst_ok", 32'(ok), 1);
        check("post_rst_ticks", 32'(n), 60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
